round_score_timer: RTL
======================

Name: round_score_timer

Overview:
- Game-round controller feeding the 8-digit seven-segment score/countdown display stage.
- Counts catches into an 8-bit score and runs a 1 Hz countdown of the round length.
- Sequences IDLE -> PLAYING -> GAME_OVER and exposes round status to the rest of the game logic.
- Both 8-bit outputs are binary, capped at 99, so the downstream two-digit BCD conversion never overflows.

Parameters:
- TICKS_PER_SEC, 100000000, CLK cycles per countdown second. Set small in simulation.
- ROUND_SECONDS, 60, countdown load value. Legal range 1..99.
- MAX_SCORE, 99, score saturation value. Legal range 1..99.

Ports:
- CLK  input  1  system clock, 100 MHz.
- RST_BTN  input  1  asynchronous, active-low reset.
- start  input  1  debounced start request, synchronous to CLK, may be held high for many cycles.
- catch_pulse  input  1  one increment per cycle it is high, from collision detection.
- score  output  8  current score, binary, 0..MAX_SCORE.
- countdown  output  8  seconds remaining, binary, 0..ROUND_SECONDS.
- game_active  output  1  high while in PLAYING.
- game_over  output  1  high while in GAME_OVER.
- sec_tick  output  1  one-cycle pulse on each countdown decrement.

Behaviour:
- Reset (RST_BTN=0, asynchronous):
  - state=IDLE, score=0, countdown=ROUND_SECONDS, prescaler=0.
  - game_active=0, game_over=0, sec_tick=0.
  - start edge-detect register=0.
- Reset mid-round takes effect immediately and aborts the round. Leaving reset needs no start edge; the block waits in IDLE.
- All outputs are registered. Effects of inputs sampled at edge k are visible after edge k (one-cycle latency).
- start_edge = start & ~start_q, where start_q is registered every cycle. A held button yields exactly one edge.
- State IDLE:
  - Outputs hold their reset values.
  - catch_pulse is ignored.
  - start_edge: score<=0, countdown<=ROUND_SECONDS, prescaler<=0, go to PLAYING.
- State PLAYING:
  - The prescaler counts 0..TICKS_PER_SEC-1.
  - At terminal count: prescaler<=0, sec_tick<=1, countdown<=countdown-1.
  - If countdown==1 at the terminal count: countdown<=0 and go to GAME_OVER on the same edge.
  - catch_pulse=1: score<=score+1 if score<MAX_SCORE, else score holds (saturating, never wraps).
  - catch_pulse on the same edge as the final tick is counted.
  - start_edge is ignored; a round cannot be restarted while playing.
  - The first decrement occurs exactly TICKS_PER_SEC cycles after entering PLAYING.
- State GAME_OVER:
  - score is frozen, countdown=0, game_over=1, game_active=0.
  - catch_pulse is ignored.
  - start_edge starts a new round exactly as from IDLE.
- game_active and game_over are derived registered from the next state, so they change on the same edge as the state.
- Only one of game_active and game_over is high at a time.
- sec_tick is high for exactly one cycle per decrement and is 0 outside PLAYING.
- Width rules: internal arithmetic is 8-bit. The prescaler is wide enough for TICKS_PER_SEC-1, using $clog2.

Test Plan (TICKS_PER_SEC=10, ROUND_SECONDS=5, MAX_SCORE=99 unless noted):
- Reset, then hold start high 50 cycles -> exactly one round starts; countdown 5,4,3,2,1,0 at 10-cycle intervals; game_over=1 on the edge countdown hits 0; five sec_tick pulses total.
- In PLAYING, 3 single-cycle catch pulses plus one 4-cycle-wide pulse -> score=7. Catch pulses in IDLE and GAME_OVER -> score unchanged.
- MAX_SCORE=3, 6 catches -> score 1,2,3,3,3,3; no wrap to 0.
- catch_pulse asserted on the final-tick cycle -> score incremented, countdown=0, game_over=1 on the same edge.
- Mid-round (countdown=3, score=4): start edge ignored. Then assert RST_BTN=0 between clock edges -> outputs go to IDLE values without waiting for CLK.
- From GAME_OVER with score=7, start edge -> next cycle score=0, countdown=5, game_active=1, game_over=0.

Source files
------------

// File: rtl/round_score_timer.sv
// round_score_timer: game-round controller with saturating score, 1 Hz countdown
// and IDLE -> PLAYING -> GAME_OVER sequencing; all outputs registered.
module round_score_timer #(
    parameter int TICKS_PER_SEC = 100000000,
    parameter int ROUND_SECONDS = 60,
    parameter int MAX_SCORE     = 99
) (
    input  logic       CLK,
    input  logic       RST_BTN,
    input  logic       start,
    input  logic       catch_pulse,
    output logic [7:0] score,
    output logic [7:0] countdown,
    output logic       game_active,
    output logic       game_over,
    output logic       sec_tick
);
    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [7:0] ROUND_LOAD = 8'(ROUND_SECONDS);
    localparam logic [7:0] SCORE_CAP  = 8'(MAX_SCORE);
    typedef enum logic [1:0] {IDLE, PLAYING, GAME_OVER} state_t;
    state_t        state_q, state_d;
    logic [7:0]    score_q, score_d, countdown_q, countdown_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          start_q, sec_tick_q, sec_tick_d;
    logic          game_active_q, game_over_q;
    logic          start_edge, presc_done;
    assign start_edge = start & ~start_q;
    assign presc_done = presc_q == PRESC_LAST;
    always_comb begin
        state_d     = state_q;
        score_d     = score_q;
        countdown_d = countdown_q;
        presc_d     = presc_q;
        sec_tick_d  = 1'b0;
        case (state_q)
            PLAYING: begin
                presc_d     = presc_done ? '0 : presc_q + PW'(1);
                sec_tick_d  = presc_done;
                countdown_d = presc_done ? countdown_q - 8'd1 : countdown_q;
                state_d     = (presc_done && countdown_q == 8'd1) ? GAME_OVER : PLAYING;
                score_d     = (catch_pulse && score_q < SCORE_CAP) ? score_q + 8'd1 : score_q;
            end
            IDLE, GAME_OVER: begin
                if (start_edge) begin
                    state_d     = PLAYING;
                    score_d     = 8'd0;
                    countdown_d = ROUND_LOAD;
                    presc_d     = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge CLK or negedge RST_BTN) begin
        if (!RST_BTN) begin
            state_q       <= IDLE;
            score_q       <= 8'd0;
            countdown_q   <= ROUND_LOAD;
            presc_q       <= '0;
            start_q       <= 1'b0;
            sec_tick_q    <= 1'b0;
            game_active_q <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            score_q       <= score_d;
            countdown_q   <= countdown_d;
            presc_q       <= presc_d;
            start_q       <= start;
            sec_tick_q    <= sec_tick_d;
            game_active_q <= state_d == PLAYING;
            game_over_q   <= state_d == GAME_OVER;
        end
    end
    assign score       = score_q;
    assign countdown   = countdown_q;
    assign game_active = game_active_q;
    assign game_over   = game_over_q;
    assign sec_tick    = sec_tick_q;
endmodule
